// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
//   Instruction-memory request bus between the fetch stage and the
//   instruction memory.
//
//   imem_req    fetch unit -> memory   a fetch request is outstanding
//   imem_addr   fetch unit -> memory   byte address of the requested word
//   imem_ready  memory -> fetch unit   pending request completes this cycle
//   imem_rdata  memory -> fetch unit   instruction word, valid with imem_ready
//
//   master: the fetch unit side; slave: the memory side.
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage of a 5-stage MIPS pipeline. Owns the program
//   counter, fetches words from a variable-latency instruction memory and
//   hands each word with its PC+4 to the IF/ID register. Drives a NOP
//   (Instruction = 0, PC = 0, fetch_valid = 0) in any cycle with nothing to
//   deliver.
//
//   Parameters
//     RESET_PC        PC loaded on reset (word aligned)
//   Ports
//     clk             pipeline clock, rising edge
//     rst             asynchronous active-high reset
//     freeze          hazard stall: no delivery this cycle
//     branch_taken    EXE-stage redirect pulse
//     branch_address  redirect target, bits [1:0] ignored
//     imem            instruction-memory bus (master side)
//     PC              PC+4 of the delivered instruction, else 0
//     Instruction     delivered instruction, else 0
//     fetch_valid     a real instruction is delivered this cycle
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [31:0]            branch_address,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            PC,
    output logic [31:0]            Instruction,
    output logic                   fetch_valid
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic [31:0] branch_target;
    logic [31:0] pc_plus4;

    // Masking keeps every target word aligned without leaving bits unused.
    assign branch_target = branch_address & ~32'h3;
    // Wraps naturally modulo 2^32.
    assign pc_plus4      = pc_q + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC & ~32'h3;
            drain_addr_q <= 32'h0;
            inst_buf_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            inst_buf_q   <= inst_buf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        drain_addr_d   = drain_addr_q;
        inst_buf_d     = inst_buf_q;
        imem.imem_req  = 1'b0;
        imem.imem_addr = 32'h0;
        PC             = 32'h0;
        Instruction    = 32'h0;
        fetch_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (branch_taken) begin
                    pc_d = branch_target;
                end
            end

            StFetch: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = pc_q;
                if (branch_taken) begin
                    pc_d = branch_target;
                    // An unfinished request cannot be withdrawn; remember its
                    // address so it can be held stable until the memory answers.
                    if (!imem.imem_ready) begin
                        drain_addr_d = pc_q;
                        state_d      = StDrain;
                    end
                end else if (imem.imem_ready && !freeze) begin
                    fetch_valid = 1'b1;
                    PC          = pc_plus4;
                    Instruction = imem.imem_rdata;
                    pc_d        = pc_plus4;
                end else if (imem.imem_ready) begin
                    inst_buf_d = imem.imem_rdata;
                    state_d    = StHold;
                end
            end

            StHold: begin
                if (branch_taken) begin
                    inst_buf_d = 32'h0;
                    pc_d       = branch_target;
                    state_d    = StFetch;
                end else if (!freeze) begin
                    fetch_valid = 1'b1;
                    PC          = pc_plus4;
                    Instruction = inst_buf_q;
                    pc_d        = pc_plus4;
                    state_d     = StFetch;
                end
            end

            StDrain: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = drain_addr_q;
                if (branch_taken) begin
                    pc_d = branch_target;
                end
                if (imem.imem_ready) begin
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed vector table for the main fetch scenarios, a randomized run
//   checked against a transaction-level model, and a hand-written sequence
//   for the wrapping reset PC and reset during a pending request.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic [31:0] pc_out, inst_out, pc_w, inst_w;
    logic        valid_out, valid_w;

    if_fetch_unit_if mem ();
    if_fetch_unit_if mem_w ();

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem           (mem),
        .PC             (pc_out),
        .Instruction    (inst_out),
        .fetch_valid    (valid_out)
    );

    if_fetch_unit #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_w (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem           (mem_w),
        .PC             (pc_w),
        .Instruction    (inst_w),
        .fetch_valid    (valid_w)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    task automatic check(input string name, input logic [97:0] got, input logic [97:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [97:0] dut_obs();
        return {mem.imem_req, mem.imem_addr, valid_out, pc_out, inst_out};
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic        m_started;
    logic [31:0] m_pc;
    logic        m_stale;       // abandoned request still awaiting its answer
    logic [31:0] m_stale_addr;
    logic        m_buf_valid;   // word fetched during a freeze, not yet handed on
    logic [31:0] m_buf;

    task automatic model_reset(input logic [31:0] rpc);
        m_started = 1'b0; m_pc = rpc; m_stale = 1'b0; m_stale_addr = 32'h0;
        m_buf_valid = 1'b0; m_buf = 32'h0;
    endtask

    task automatic model_bus(output logic req, output logic [31:0] addr);
        if (!m_started || m_buf_valid) begin
            req = 1'b0; addr = 32'h0;
        end else if (m_stale) begin
            req = 1'b1; addr = m_stale_addr;
        end else begin
            req = 1'b1; addr = m_pc;
        end
    endtask

    task automatic model_step(input logic f, input logic b, input logic [31:0] t,
                              input logic r, input logic [31:0] rd, output logic v,
                              output logic [31:0] opc, output logic [31:0] oinst);
        logic [31:0] tgt;
        tgt = t & ~32'h3;
        v = 1'b0; opc = 32'h0; oinst = 32'h0;
        if (!m_started) begin
            m_started = 1'b1;
            if (b) m_pc = tgt;
        end else if (m_buf_valid) begin
            if (b) begin
                m_buf_valid = 1'b0; m_pc = tgt;
            end else if (!f) begin
                v = 1'b1; opc = m_pc + 32'd4; oinst = m_buf;
                m_pc = m_pc + 32'd4; m_buf_valid = 1'b0;
            end
        end else if (m_stale) begin
            if (b) m_pc = tgt;
            if (r) m_stale = 1'b0;
        end else if (b) begin
            if (!r) begin
                m_stale = 1'b1; m_stale_addr = m_pc;
            end
            m_pc = tgt;
        end else if (r && !f) begin
            v = 1'b1; opc = m_pc + 32'd4; oinst = rd; m_pc = m_pc + 32'd4;
        end else if (r) begin
            m_buf = rd; m_buf_valid = 1'b1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic apply(input logic f, input logic b, input logic [31:0] t,
                         input logic r, input logic [31:0] rd);
        freeze = f; branch_taken = b; branch_address = t;
        mem.imem_ready = r; mem.imem_rdata = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from a clock edge, check outputs, release before next negedge.
    task automatic do_reset(input string name);
        @(posedge clk);
        #1;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
        mem.imem_ready = 1'b0; mem.imem_rdata = 32'h0;
        mem_w.imem_ready = 1'b0; mem_w.imem_rdata = 32'h0;
        #1;
        check(name, dut_obs(), 98'h0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset(32'h0);
    endtask

    typedef struct {
        logic        f, b, r;
        logic [31:0] t;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    localparam int NVec = 27;
    vec_t vec [NVec];

    function automatic vec_t mk(input logic f, input logic b, input logic [31:0] t,
                                input logic r, input logic e_req, input logic [31:0] e_addr,
                                input logic e_v, input logic [31:0] e_pc,
                                input logic [31:0] e_inst);
        vec_t x;
        x.f = f; x.b = b; x.t = t; x.r = r; x.e_req = e_req; x.e_addr = e_addr;
        x.e_v = e_v; x.e_pc = e_pc; x.e_inst = e_inst;
        return x;
    endfunction

    initial begin
        logic        ereq, ev, r, f, b;
        logic [31:0] eaddr, epc, einst, rd, t;

        mem.imem_ready = 1'b0; mem.imem_rdata = 32'h0;
        mem_w.imem_ready = 1'b0; mem_w.imem_rdata = 32'h0;

        //            f  b  target        r  req addr          v  PC            Instruction
        vec[0]  = mk(0, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       32'h0);
        vec[1]  = mk(0, 0, 32'h0,       1, 1, 32'h0,        1, 32'h4,       word_of(32'h0));
        vec[2]  = mk(0, 0, 32'h0,       1, 1, 32'h4,        1, 32'h8,       word_of(32'h4));
        vec[3]  = mk(0, 0, 32'h0,       1, 1, 32'h8,        1, 32'hC,       word_of(32'h8));
        vec[4]  = mk(0, 0, 32'h0,       1, 1, 32'hC,        1, 32'h10,      word_of(32'hC));
        vec[5]  = mk(0, 0, 32'h0,       0, 1, 32'h10,       0, 32'h0,       32'h0);
        vec[6]  = mk(0, 0, 32'h0,       0, 1, 32'h10,       0, 32'h0,       32'h0);
        vec[7]  = mk(0, 0, 32'h0,       1, 1, 32'h10,       1, 32'h14,      word_of(32'h10));
        vec[8]  = mk(1, 0, 32'h0,       0, 1, 32'h14,       0, 32'h0,       32'h0);
        vec[9]  = mk(1, 0, 32'h0,       1, 1, 32'h14,       0, 32'h0,       32'h0);
        vec[10] = mk(1, 0, 32'h0,       0, 0, 32'h0,        0, 32'h0,       32'h0);
        vec[11] = mk(0, 0, 32'h0,       0, 0, 32'h0,        1, 32'h18,      word_of(32'h14));
        vec[12] = mk(0, 0, 32'h0,       1, 1, 32'h18,       1, 32'h1C,      word_of(32'h18));
        vec[13] = mk(0, 0, 32'h0,       1, 1, 32'h1C,       1, 32'h20,      word_of(32'h1C));
        vec[14] = mk(0, 0, 32'h0,       0, 1, 32'h20,       0, 32'h0,       32'h0);
        vec[15] = mk(0, 1, 32'h100,     0, 1, 32'h20,       0, 32'h0,       32'h0);
        vec[16] = mk(0, 0, 32'h0,       0, 1, 32'h20,       0, 32'h0,       32'h0);
        vec[17] = mk(0, 0, 32'h0,       1, 1, 32'h20,       0, 32'h0,       32'h0);
        vec[18] = mk(0, 0, 32'h0,       1, 1, 32'h100,      1, 32'h104,     word_of(32'h100));
        vec[19] = mk(1, 0, 32'h0,       1, 1, 32'h104,      0, 32'h0,       32'h0);
        vec[20] = mk(1, 1, 32'h203,     0, 0, 32'h0,        0, 32'h0,       32'h0);
        vec[21] = mk(0, 0, 32'h0,       1, 1, 32'h200,      1, 32'h204,     word_of(32'h200));
        vec[22] = mk(0, 1, 32'h40,      1, 1, 32'h204,      0, 32'h0,       32'h0);
        vec[23] = mk(0, 0, 32'h0,       1, 1, 32'h40,       1, 32'h44,      word_of(32'h40));
        vec[24] = mk(0, 1, 32'h80,      0, 1, 32'h44,       0, 32'h0,       32'h0);
        vec[25] = mk(0, 1, 32'h93,      1, 1, 32'h44,       0, 32'h0,       32'h0);
        vec[26] = mk(0, 0, 32'h0,       1, 1, 32'h90,       1, 32'h94,      word_of(32'h90));

        // ---------------- directed table ----------------
        do_reset("reset_main");
        for (int i = 0; i < NVec; i++) begin
            // Non-ready cycles carry junk data so a wrong capture shows up.
            apply(vec[i].f, vec[i].b, vec[i].t, vec[i].r,
                  vec[i].r ? word_of(vec[i].e_addr) : 32'hBAD0_BAD0);
            check($sformatf("vec%0d", i), dut_obs(),
                  {vec[i].e_req, vec[i].e_addr, vec[i].e_v, vec[i].e_pc, vec[i].e_inst});
            tick();
        end

        // ---------------- randomized run against the model ----------------
        do_reset("reset_random");
        for (int i = 0; i < 1500; i++) begin
            model_bus(ereq, eaddr);
            f  = ($urandom % 4) == 0;
            b  = ($urandom % 10) == 0;
            t  = $urandom;
            r  = ereq && (($urandom % 3) != 0);
            rd = r ? word_of(eaddr) : $urandom;
            apply(f, b, t, r, rd);
            model_step(f, b, t, r, rd, ev, epc, einst);
            check($sformatf("rand%0d", i), dut_obs(), {ereq, eaddr, ev, epc, einst});
            tick();
        end

        // ---------------- wrapping reset PC, reset mid-request ----------------
        do_reset("reset_wrap");
        #1;
        check("wrap_idle", {mem_w.imem_req, valid_w}, 98'h0);
        tick();
        mem_w.imem_ready = 1'b1;
        mem_w.imem_rdata = word_of(32'hFFFF_FFFC);
        #1;
        check("wrap_first", {mem_w.imem_req, mem_w.imem_addr, valid_w, pc_w, inst_w},
              {1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0, word_of(32'hFFFF_FFFC)});
        tick();
        mem_w.imem_ready = 1'b0;
        mem_w.imem_rdata = 32'hBAD0_BAD0;
        #1;
        check("wrap_next_addr", {mem_w.imem_req, mem_w.imem_addr, valid_w},
              {64'h0, 1'b1, 32'h0, 1'b0});
        tick();
        check("wait_req_high", {mem_w.imem_req, mem_w.imem_addr}, {65'h0, 1'b1, 32'h0});
        rst = 1'b1;
        #1;
        check("rst_drops_req", {mem_w.imem_req, mem_w.imem_addr, valid_w, pc_w, inst_w}, 98'h0);
        check("rst_drops_req_main", dut_obs(), 98'h0);
        tick();
        #3;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID pipeline register. Owns the program counter, fetches instructions from a variable-latency instruction memory over a req/ready handshake, and hands each fetched instruction with its PC+4 to the IF/ID register. Honours the hazard unit's freeze and the EXE stage's branch redirect. Emits a NOP (32'b0) with PC 0 in any cycle it has nothing to deliver.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low two bits must be 00.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- freeze  input  1  hazard stall; IF/ID holds its contents, no delivery this cycle.
- branch_taken  input  1  EXE-stage redirect, one-cycle pulse.
- branch_address  input  32  redirect target; bits [1:0] ignored, treated as 00.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of requested word; stable while imem_req high and imem_ready low.
- imem_ready  input  1  memory completes the pending request this cycle; may be asserted in the same cycle as imem_req (zero-wait).
- imem_rdata  input  32  instruction word, valid only when imem_ready high.
- PC  output  32  PC+4 of delivered instruction, to IF/ID PC_in; 0 when not delivering.
- Instruction  output  32  delivered instruction, to IF/ID Instruction_in; 0 (NOP) when not delivering.
- fetch_valid  output  1  high in cycles that deliver a real instruction.

## Operation
- Registers: pc (next address to fetch), drain_addr, inst_buf, 2-bit state.
- States: IDLE, FETCH, HOLD, DRAIN. Reset: state=IDLE, pc=RESET_PC, inst_buf=0, drain_addr=0.
- IDLE: imem_req=0; next state FETCH (pc updated if branch_taken).
- FETCH: imem_req=1, imem_addr=pc.
  - branch_taken (any freeze/ready): pc<=target; if imem_ready then FETCH (data discarded), else drain_addr<=pc, go DRAIN.
  - imem_ready & !freeze: deliver imem_rdata, PC=pc+4, pc<=pc+4, stay FETCH.
  - imem_ready & freeze: inst_buf<=imem_rdata, go HOLD; pc unchanged.
  - !imem_ready: wait.
- HOLD: imem_req=0. branch_taken: discard buffer, pc<=target, go FETCH. Else !freeze: deliver inst_buf, PC=pc+4, pc<=pc+4, go FETCH. Else stay.
- DRAIN: imem_req=1, imem_addr=drain_addr (stale request held until completion). branch_taken: pc<=newest target. imem_ready: data discarded, go FETCH. Nothing delivered in DRAIN.
- Priority: rst > branch_taken > freeze > imem_ready.
- Delivery (fetch_valid=1) only in FETCH or HOLD, combinational in the handshake/release cycle; never with branch_taken or freeze high.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Async rst mid-request: state IDLE immediately, imem_req drops; memory must accept abandoned request.

## Timing
- After rst deassert: 1 cycle IDLE, then first request at RESET_PC.
- Zero-wait memory, no stalls: one instruction per cycle, addresses RESET_PC, +4, +8, ...
- Fetch latency: delivery in the cycle imem_ready rises (N wait cycles → N+1 cycles per instruction).
- Freeze release from HOLD: delivery in first cycle freeze is low; next request the following cycle.
- Branch: target requested the cycle after branch_taken (FETCH path) or the cycle after the drained ready.
- Outputs PC, Instruction, fetch_valid, imem_req, imem_addr combinational from state/inputs; all 0 during reset.

## Test plan
- Reset, zero-wait memory returning addr-derived words: imem_addr 0,4,8 on consecutive cycles; PC outputs 4,8,12; fetch_valid continuous.
- 2-wait memory at address 0x10: imem_addr held 0x10 three cycles, PC/Instruction 0 first two, delivery (PC=0x14) on third.
- freeze high 3 cycles spanning ready: word captured, Instruction=0 while frozen, delivered with PC=pc+4 in release cycle, no re-fetch.
- branch_taken to 0x100 while request to 0x20 waiting 3 cycles: imem_addr stays 0x20 until ready, data discarded, next request 0x100, no delivery meanwhile.
- branch_taken together with freeze in HOLD: buffer dropped, next request at target, first delivery PC=target+4.
- RESET_PC=0xFFFF_FFFC: first delivery PC=0, next imem_addr=0; rst asserted mid-wait drops imem_req same cycle.
